// File: rtl/fadd_scheduler.sv
// fadd_scheduler: round-robin issue control for two clients into a pipelined
// float adder, with ID tags, credits and optional subtract (FADD_SCHED_SUB_EN).
module fadd_scheduler #(
   parameter int FADD_LAT = 67,
   parameter int MAX_OUT  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
`ifdef FADD_SCHED_SUB_EN
   input  logic        req0_sub,
   input  logic        req1_sub,
`endif
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        rsp0_valid,
   output logic [31:0] rsp0_data,
   output logic        rsp1_valid,
   output logic [31:0] rsp1_data,
   output logic [31:0] fadd_a,
   output logic [31:0] fadd_b,
   input  logic [31:0] fadd_out,
   output logic        busy
);

   localparam int CW = $clog2(MAX_OUT + 1);
   localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);

   logic [CW-1:0]       cred0_q, cred0_d;
   logic [CW-1:0]       cred1_q, cred1_d;
   logic                last_q;
   logic [FADD_LAT-1:0] tv_q;
   logic [FADD_LAT-1:0] tid_q;
   logic                ret_q, rid_q;
   logic                rsp0_valid_q, rsp1_valid_q;
   logic [31:0]         rsp0_data_q, rsp1_data_q;
   logic [31:0]         fadd_a_q, fadd_b_q;

   logic        elig0, elig1, gnt0, gnt1, acc;
   logic        ret, rid, ret0, ret1;
   logic [31:0] op_a, op_b, op_b_eff;

   assign ret  = tv_q[FADD_LAT-1];
   assign rid  = tid_q[FADD_LAT-1];
   assign ret0 = ret && !rid;
   assign ret1 = ret && rid;

   // Eligibility and round-robin grant on current credits and pointer
   always_comb begin
      elig0 = req0_valid && (cred0_q < MAX_C);
      elig1 = req1_valid && (cred1_q < MAX_C);
      gnt0  = elig0 && (!elig1 || last_q);
      gnt1  = elig1 && (!elig0 || !last_q);
      acc   = gnt0 || gnt1;
   end

   // Operand mux with optional sign flip of b for subtraction
   always_comb begin
      op_a     = gnt1 ? req1_a : req0_a;
      op_b     = gnt1 ? req1_b : req0_b;
      op_b_eff = op_b;
`ifdef FADD_SCHED_SUB_EN
      if (gnt1 ? req1_sub : req0_sub)
         op_b_eff = {~op_b[31], op_b[30:0]};
`endif
   end

   // Credit next-state: accept adds, retire frees, both cancel
   always_comb begin
      cred0_d = cred0_q;
      cred1_d = cred1_q;
      if (gnt0 && !ret0)
         cred0_d = cred0_q + CW'(1);
      else if (!gnt0 && ret0)
         cred0_d = cred0_q - CW'(1);
      if (gnt1 && !ret1)
         cred1_d = cred1_q + CW'(1);
      else if (!gnt1 && ret1)
         cred1_d = cred1_q - CW'(1);
   end

   // Issue registers, credits and arbitration pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cred0_q  <= '0;
         cred1_q  <= '0;
         last_q   <= 1'b1;
         fadd_a_q <= '0;
         fadd_b_q <= '0;
      end else begin
         cred0_q <= cred0_d;
         cred1_q <= cred1_d;
         if (acc) begin
            last_q   <= gnt1;
            fadd_a_q <= op_a;
            fadd_b_q <= op_b_eff;
         end
      end
   end

   // Tag delay line matched to adder latency; never stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tv_q  <= '0;
         tid_q <= '0;
      end else begin
         tv_q[0]  <= acc;
         tid_q[0] <= gnt1;
         for (int i = 1; i < FADD_LAT; i++) begin
            tv_q[i]  <= tv_q[i-1];
            tid_q[i] <= tid_q[i-1];
         end
      end
   end

   // Retire: capture adder result one edge after the tag leaves the line
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ret_q        <= 1'b0;
         rid_q        <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_data_q  <= '0;
         rsp1_data_q  <= '0;
      end else begin
         ret_q        <= ret;
         rid_q        <= rid;
         rsp0_valid_q <= ret_q && !rid_q;
         rsp1_valid_q <= ret_q && rid_q;
         if (ret_q && !rid_q)
            rsp0_data_q <= fadd_out;
         if (ret_q && rid_q)
            rsp1_data_q <= fadd_out;
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign fadd_a     = fadd_a_q;
   assign fadd_b     = fadd_b_q;
   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp0_data  = rsp0_data_q;
   assign rsp1_data  = rsp1_data_q;
   assign busy       = |tv_q;

endmodule

// File: tb/tb_fadd_scheduler.sv
// tb_fadd_scheduler: randomized and directed checks of fadd_scheduler
// against a queue-based model and an ideal integer-valued float adder.
module tb_fadd_scheduler;

   localparam int LAT = 67;
   localparam int MO  = 8;

   logic        clk, rst;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        req0_sub, req1_sub;
   logic        rsp0_valid, rsp1_valid;
   logic [31:0] rsp0_data, rsp1_data;
   logic [31:0] fadd_a, fadd_b, fadd_out;
   logic        busy;

   fadd_scheduler #(.FADD_LAT(LAT), .MAX_OUT(MO)) dut (
      .clk(clk),
      .rst(rst),
      .req0_valid(req0_valid),
      .req0_ready(req0_ready),
      .req0_a(req0_a),
      .req0_b(req0_b),
`ifdef FADD_SCHED_SUB_EN
      .req0_sub(req0_sub),
      .req1_sub(req1_sub),
`endif
      .req1_valid(req1_valid),
      .req1_ready(req1_ready),
      .req1_a(req1_a),
      .req1_b(req1_b),
      .rsp0_valid(rsp0_valid),
      .rsp0_data(rsp0_data),
      .rsp1_valid(rsp1_valid),
      .rsp1_data(rsp1_data),
      .fadd_a(fadd_a),
      .fadd_b(fadd_b),
      .fadd_out(fadd_out),
      .busy(busy)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Integer-valued float helpers (exact for magnitudes below 2^24)
   function automatic logic [31:0] int2f(input int v);
      int m, p;
      logic [31:0] r;
      if (v == 0) return 32'h0;
      m = (v < 0) ? -v : v;
      p = 0;
      for (int i = 0; i < 31; i++)
         if ((m >> i) != 0) p = i;
      r[31]    = (v < 0);
      r[30:23] = 8'(127 + p);
      r[22:0]  = 23'(m << (23 - p));
      return r;
   endfunction

   function automatic int f2int(input logic [31:0] f);
      int e, mag;
      if (f[30:23] == 8'd0) return 0;
      e   = int'(f[30:23]) - 127;
      mag = int'({1'b1, f[22:0]}) >> (23 - e);
      return f[31] ? -mag : mag;
   endfunction

   function automatic logic [31:0] fadd_model(input logic [31:0] a,
                                              input logic [31:0] b);
      return int2f(f2int(a) + f2int(b));
   endfunction

   function automatic logic [31:0] beff(input logic [31:0] b, input bit s);
`ifdef FADD_SCHED_SUB_EN
      return s ? {~b[31], b[30:0]} : b;
`else
      return b;
`endif
   endfunction

   // Ideal adder: LAT-deep delay of the float sum
   logic [31:0] apipe [LAT];
   always @(posedge clk) begin
      apipe[0] <= fadd_model(fadd_a, fadd_b);
      for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
   end
   assign fadd_out = apipe[LAT-1];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          e;
      bit          id;
      logic [31:0] d;
   } op_t;

   op_t q[$];
   int  edge_n;
   bit  last_m;

   task automatic outstanding(output int n0, output int n1);
      n0 = 0;
      n1 = 0;
      foreach (q[i])
         if (q[i].e + LAT > edge_n) begin
            if (q[i].id) n1++;
            else n0++;
         end
   endtask

   task automatic step(input bit v0, input bit v1,
                       input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1,
                       input bit s0, input bit s1);
      int n0, n1;
      bit e0, e1, g0, g1, due, did;
      logic [31:0] ea, eb, dd;
      req0_valid = v0; req1_valid = v1;
      req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
      req0_sub = s0; req1_sub = s1;
      #1;
      outstanding(n0, n1);
      e0 = v0 && (n0 < MO);
      e1 = v1 && (n1 < MO);
      g0 = e0 && (!e1 || last_m);
      g1 = e1 && (!e0 || !last_m);
      chk("ready0", 32'(req0_ready), 32'(g0));
      chk("ready1", 32'(req1_ready), 32'(g1));
      ea = g1 ? a1 : a0;
      eb = g1 ? beff(b1, s1) : beff(b0, s0);
      @(posedge clk);
      edge_n++;
      if (g0 || g1) begin
         q.push_back('{edge_n, g1, fadd_model(ea, eb)});
         last_m = g1;
      end
      @(negedge clk);
      if (g0 || g1) begin
         chk("fadd_a", fadd_a, ea);
         chk("fadd_b", fadd_b, eb);
      end
      due = 0; did = 0; dd = '0;
      foreach (q[i])
         if (q[i].e + LAT + 1 == edge_n) begin
            due = 1; did = q[i].id; dd = q[i].d;
         end
      chk("rsp0_valid", 32'(rsp0_valid), 32'(due && !did));
      chk("rsp1_valid", 32'(rsp1_valid), 32'(due && did));
      if (due && !did) chk("rsp0_data", rsp0_data, dd);
      if (due && did) chk("rsp1_data", rsp1_data, dd);
      while (q.size() > 0 && q[0].e + LAT + 1 <= edge_n) void'(q.pop_front());
      outstanding(n0, n1);
      chk("cred0", 32'(dut.cred0_q), n0);
      chk("cred1", 32'(dut.cred1_q), n1);
      chk("busy", 32'(busy), 32'((n0 + n1) > 0));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   function automatic logic [31:0] rnd_f();
      return int2f(int'($urandom_range(0, 1 << 20)));
   endfunction

   task automatic mid_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rsp0", 32'(rsp0_valid), 0);
      chk("rst_rsp1", 32'(rsp1_valid), 0);
      chk("rst_fadd_a", fadd_a, 0);
      q.delete();
      last_m = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst    = 1'b0;
      edge_n = 0;
   endtask

   initial begin
      rst = 1'b1;
      req0_valid = 0; req1_valid = 0;
      req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
      req0_sub = 0; req1_sub = 0;
      edge_n = 0;
      last_m = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_rsp0v", 32'(rsp0_valid), 0);
      chk("reset_rsp1v", 32'(rsp1_valid), 0);
      chk("reset_rsp0d", rsp0_data, 0);
      chk("reset_fadd_b", fadd_b, 0);
      rst = 1'b0;

      // single op latency
      step(1, 0, 32'h3F800000, 32'h3F800000, 0, 0, 0, 0);
      idle(LAT + 3);

      // round-robin tie
      for (int i = 0; i < 20; i++)
         step(1, 1, rnd_f(), rnd_f(), rnd_f(), rnd_f(), 0, 0);
      idle(LAT + 3);

      // credit exhaustion on req0
      for (int i = 0; i < LAT + 20; i++)
         step(1, 0, rnd_f(), rnd_f(), 0, 0, 0, 0);
      idle(LAT + 3);

      // simultaneous accept and retire with three outstanding
      mid_reset();
      for (int i = 0; i < 3; i++) step(1, 0, rnd_f(), rnd_f(), 0, 0, 0, 0);
      idle(LAT - 3);
      for (int i = 0; i < 3; i++) step(1, 0, rnd_f(), rnd_f(), 0, 0, 0, 0);
      chk("cred0_hold", 32'(dut.cred0_q), 3);
      idle(LAT + 3);

      // reset mid-flight
      for (int i = 0; i < 5; i++) step(1, 0, rnd_f(), rnd_f(), 0, 0, 0, 0);
      idle(14);
      mid_reset();
      idle(LAT + 5);
      step(0, 1, 0, 0, 32'h40400000, 32'h40A00000, 0, 0);
      idle(LAT + 3);

`ifdef FADD_SCHED_SUB_EN
      step(0, 1, 0, 0, 32'h40400000, 32'h3F800000, 0, 1);
      chk("sub_fadd_b", fadd_b, 32'hBF800000);
      idle(LAT + 3);
`endif

      // randomized traffic
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
              rnd_f(), rnd_f(), rnd_f(), rnd_f(),
              $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
      idle(LAT + 3);
      chk("drained", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
